interrupt_ack_sequencer: RTL
============================

// Module: interrupt_ack_sequencer
// PURPOSE
//  CPU-facing INTA responder of the 8259A PIC; produces the latch_in_service / end_of_interrupt
//  strobes that the In_Service block consumes. Raises int_out when a resolved request is pending,
//  then steps through the INTA pulse train (2 pulses 8086, 3 pulses 8080), driving the vector or
//  CALL bytes onto the data bus. Sits between priority resolver, In_Service and the bus buffer.
// PARAMETERS
//  SYNC_STAGES  2  flops synchronising inta_n before edge detection (>=2)
// PORTS
//  clk                   in   1  system clock; all logic on rising edge
//  rst_n                 in   1  synchronous reset, active low
//  interrupt_request     in   8  resolved pending request from priority resolver (expected one-hot)
//  inta_n                in   1  CPU interrupt acknowledge pin, active low, asynchronous
//  mode_8086             in   1  1: 8086 two-pulse sequence; 0: 8080 three-pulse sequence
//  auto_eoi              in   1  1: issue end_of_interrupt at end of sequence
//  vector_base           in   5  8086 vector bits T7..T3
//  address_low           in   3  8080 CALL address A7..A5
//  address_high          in   8  8080 CALL address A15..A8
//  adi                   in   1  8080 address interval: 1 = 4 bytes, 0 = 8 bytes
//  int_out               out  1  interrupt request to CPU
//  latch_in_service      out  1  one-cycle strobe: set in-service bit(s) given by acknowledged_level
//  acknowledged_level    out  8  one-hot level captured at first INTA (0 = spurious)
//  end_of_interrupt      out  8  one-cycle auto-EOI strobe, one-hot level to clear
//  data_out              out  8  byte for data bus
//  data_out_en           out  1  bus buffer drive enable
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): state IDLE; all outputs 0; synchroniser flops = 1 (inta high).
//  inta_n -> SYNC_STAGES flops -> previous-value flop; fall = prev&~cur, rise = ~prev&cur.
//  States: IDLE, ACK1, ACK2, ACK3 (ACK3 8080 only). Current pulse index tracked by state.
//  IDLE: int_out <= |interrupt_request (registered, 1-cycle latency). On fall: capture mode_8086,
//   auto_eoi into shadow regs; capture lowest-set bit of interrupt_request into acknowledged_level
//   (multiple bits -> lowest index wins); pulse latch_in_service next cycle iff level != 0;
//   int_out <= 0; go ACK1. fall while int_out=0 still starts a sequence (spurious handling).
//  Spurious: acknowledged_level = 0 -> no latch_in_service, no EOI; vector/address use level 7.
//  level number L = encode(acknowledged_level), or 7 if spurious.
//  ACK1: 8086 -> data_out_en stays 0. 8080 -> data_out = 8'hCD, data_out_en = 1 while pulse low.
//   On rise: data_out_en <= 0; go ACK2.
//  ACK2 on fall: data_out_en <= 1; data_out = 8086 {vector_base, L[2:0]};
//   8080 adi=1 {address_low, L[2:0], 2'b00}; adi=0 {address_low[2:1], L[2:0], 3'b000}.
//   On rise: data_out_en <= 0; 8086 -> go IDLE (end); 8080 -> go ACK3.
//  ACK3 on fall: data_out = address_high, data_out_en <= 1. On rise: data_out_en <= 0; go IDLE (end).
//  End of sequence: if shadow auto_eoi and level != 0, end_of_interrupt <= acknowledged_level for
//   exactly one cycle. int_out may re-assert no earlier than the cycle after returning to IDLE.
//  data_out_en asserts the cycle after fall is detected, drops the cycle after rise is detected.
//  data_out = 0 whenever data_out_en = 0.
//  Mode/base/address inputs changing mid-sequence: mode_8086/auto_eoi use shadow copies;
//   vector_base/address_* sampled at the fall of the pulse that drives them.
//  rst_n low mid-sequence: immediate return to IDLE at that edge; no EOI issued; bus released.
//  interrupt_request dropping after first fall: ignored (level already captured).
// STRUCTURE
//  Shared package pic_8259_pkg: state encoding (IDLE/ACK1/ACK2/ACK3), CALL_OPCODE = 8'hCD,
//   SPURIOUS_LEVEL = 3'd7, onehot-to-binary and lowest-bit-select functions.
//  Sub-module inta_edge_detector (synchroniser + fall/rise pulses, SYNC_STAGES parameter).
// TESTING
//  8086: req=8'b0000_0100, base=5'b01000, two INTA pulses -> int_out 1 then 0 after 1st fall,
//   latch_in_service 1 cycle with level 8'h04, 2nd pulse data_out=8'h42, data_out_en only on 2nd.
//  8080 adi=1: req=8'h20, low=3'b101, high=8'h12 -> bytes 8'hCD, 8'hB4, 8'h12 on pulses 1..3.
//  auto_eoi=1, req=8'h01, 8086 -> end_of_interrupt=8'h01 for exactly 1 cycle after 2nd rise; 0 if auto_eoi=0.
//  Spurious: req drops to 0 before 1st INTA, base=5'b00001 -> no latch, no EOI, vector 8'h0F.
//  Multi-bit req=8'b0011_0000 -> level 8'h10 latched; mode_8086 toggled mid-sequence ignored.
//  rst_n low during 2nd pulse of 8080 -> next cycle all outputs 0, state IDLE, fresh sequence works.

Source files
------------

// File: rtl/pic_8259_pkg.sv
// Shared types and helpers for the 8259A PIC blocks: INTA state encoding, CALL opcode,
// spurious level and one-hot helpers.
package pic_8259_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAck1,
    StAck2,
    StAck3
  } state_e;

  localparam logic [7:0] CALL_OPCODE    = 8'hCD;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Isolates the lowest set bit; lowest index wins on multi-bit requests.
  function automatic logic [7:0] lowest_bit(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] onehot_to_bin(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/inta_edge_detector.sv
// Synchronises the asynchronous INTA pin and produces single-cycle fall/rise pulses.
module inta_edge_detector #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inta_n,
  output logic o_fall,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_cur;

  assign w_cur = r_sync[SYNC_STAGES-1];

  // Flops reset to 1 so a released pin never looks like an edge coming out of reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_inta_n};
      r_prev <= w_cur;
    end
  end

  assign o_fall = r_prev & ~w_cur;
  assign o_rise = ~r_prev & w_cur;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA responder of the 8259A: raises int_out, walks the INTA pulse train and drives the
// vector / CALL bytes, plus the in-service latch and auto-EOI strobes.
module interrupt_ack_sequencer
  import pic_8259_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_interrupt_request,
  input  logic       i_inta_n,
  input  logic       i_mode_8086,
  input  logic       i_auto_eoi,
  input  logic [4:0] i_vector_base,
  input  logic [2:0] i_address_low,
  input  logic [7:0] i_address_high,
  input  logic       i_adi,
  output logic       o_int_out,
  output logic       o_latch_in_service,
  output logic [7:0] o_acknowledged_level,
  output logic [7:0] o_end_of_interrupt,
  output logic [7:0] o_data_out,
  output logic       o_data_out_en
);

  state_e     r_state, w_state_d;
  logic       r_int_out, w_int_out_d;
  logic       r_latch, w_latch_d;
  logic [7:0] r_level, w_level_d;
  logic [7:0] r_eoi, w_eoi_d;
  logic [7:0] r_data, w_data_d;
  logic       r_data_en, w_data_en_d;
  logic       r_mode_8086, w_mode_8086_d;
  logic       r_auto_eoi, w_auto_eoi_d;

  logic       w_fall, w_rise, w_seq_end;
  logic [2:0] w_lvl_num;
  logic [7:0] w_vec_byte;

  inta_edge_detector #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inta_n(i_inta_n),
    .o_fall  (w_fall),
    .o_rise  (w_rise)
  );

  assign w_lvl_num = (r_level == 8'd0) ? SPURIOUS_LEVEL : onehot_to_bin(r_level);

  // Second-pulse byte; base/address inputs are taken live at the fall that drives them.
  always_comb begin
    w_vec_byte = 8'd0;
    if (r_mode_8086) begin
      w_vec_byte = {i_vector_base, w_lvl_num};
    end else if (i_adi) begin
      w_vec_byte = {i_address_low, w_lvl_num, 2'b00};
    end else begin
      w_vec_byte = {i_address_low[2:1], w_lvl_num, 3'b000};
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_int_out_d   = 1'b0;
    w_latch_d     = 1'b0;
    w_level_d     = r_level;
    w_eoi_d       = 8'd0;
    w_data_d      = r_data;
    w_data_en_d   = r_data_en;
    w_mode_8086_d = r_mode_8086;
    w_auto_eoi_d  = r_auto_eoi;
    w_seq_end     = 1'b0;

    case (r_state)
      StIdle: begin
        w_int_out_d = |i_interrupt_request;
        if (w_fall) begin
          w_int_out_d   = 1'b0;
          w_mode_8086_d = i_mode_8086;
          w_auto_eoi_d  = i_auto_eoi;
          w_level_d     = lowest_bit(i_interrupt_request);
          w_latch_d     = |i_interrupt_request;
          w_state_d     = StAck1;
          if (!i_mode_8086) begin
            w_data_d    = CALL_OPCODE;
            w_data_en_d = 1'b1;
          end
        end
      end
      StAck1: begin
        if (w_rise) begin
          w_data_d    = 8'd0;
          w_data_en_d = 1'b0;
          w_state_d   = StAck2;
        end
      end
      StAck2: begin
        if (w_fall) begin
          w_data_d    = w_vec_byte;
          w_data_en_d = 1'b1;
        end else if (w_rise) begin
          w_data_d    = 8'd0;
          w_data_en_d = 1'b0;
          if (r_mode_8086) begin
            w_state_d = StIdle;
            w_seq_end = 1'b1;
          end else begin
            w_state_d = StAck3;
          end
        end
      end
      StAck3: begin
        if (w_fall) begin
          w_data_d    = i_address_high;
          w_data_en_d = 1'b1;
        end else if (w_rise) begin
          w_data_d    = 8'd0;
          w_data_en_d = 1'b0;
          w_state_d   = StIdle;
          w_seq_end   = 1'b1;
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_data_d    = 8'd0;
        w_data_en_d = 1'b0;
      end
    endcase

    if (w_seq_end && r_auto_eoi && (r_level != 8'd0)) begin
      w_eoi_d = r_level;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_int_out   <= 1'b0;
      r_latch     <= 1'b0;
      r_level     <= 8'd0;
      r_eoi       <= 8'd0;
      r_data      <= 8'd0;
      r_data_en   <= 1'b0;
      r_mode_8086 <= 1'b0;
      r_auto_eoi  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_int_out   <= w_int_out_d;
      r_latch     <= w_latch_d;
      r_level     <= w_level_d;
      r_eoi       <= w_eoi_d;
      r_data      <= w_data_d;
      r_data_en   <= w_data_en_d;
      r_mode_8086 <= w_mode_8086_d;
      r_auto_eoi  <= w_auto_eoi_d;
    end
  end

  assign o_int_out            = r_int_out;
  assign o_latch_in_service   = r_latch;
  assign o_acknowledged_level = r_level;
  assign o_end_of_interrupt   = r_eoi;
  assign o_data_out           = r_data;
  assign o_data_out_en        = r_data_en;

endmodule
